// File: rtl/pc_ctrl.sv
// Fetch-side program counter controller: owns the PC, sequences boot, redirect
// flush, stall/hold and misaligned-target halt, and keeps saturating counters.
module pc_ctrl #(
    parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
    parameter int          BOOT_CYCLES  = 2,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    input  logic        hold_bus_i,
    output logic [31:0] pc_o,
    output logic        inst_req_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic        halt_o,
    output logic [31:0] jump_cnt_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);
    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        inst_req_q, inst_req_d;
    logic        halt_q, halt_d;
    logic [3:0]  boot_cnt_q, boot_cnt_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [31:0] jump_cnt_q, jump_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        valid_jump;
    logic        jump_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_ADDR;
            inst_req_q  <= 1'b0;
            halt_q      <= 1'b0;
            boot_cnt_q  <= '0;
            flush_cnt_q <= '0;
            jump_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_req_q  <= inst_req_d;
            halt_q      <= halt_d;
            boot_cnt_q  <= boot_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            jump_cnt_q  <= jump_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_req_d  = inst_req_q;
        halt_d      = halt_q;
        boot_cnt_d  = boot_cnt_q;
        flush_cnt_d = flush_cnt_q;
        stall_o     = 1'b0;
        flush_o     = 1'b0;
        valid_jump  = 1'b0;
        jump_taken  = 1'b0;

        case (state_q)
            BOOT: begin
                flush_o = 1'b1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d    = RUN;
                    inst_req_d = 1'b1;
                end else begin
                    boot_cnt_d = boot_cnt_q + 4'd1;
                end
            end
            RUN, HOLD: begin
                // A jump arriving inside the flush window belongs to a squashed instruction.
                valid_jump = jump_en_i && (flush_cnt_q == 3'd0);
                stall_o    = hold_bus_i | (hold_flag_i & ~valid_jump);
                flush_o    = valid_jump | (flush_cnt_q != 3'd0);
                if (valid_jump && jump_addr_i[1]) begin
                    state_d    = HALT;
                    halt_d     = 1'b1;
                    inst_req_d = 1'b0;
                end else if (valid_jump) begin
                    // The redirect completes even under a bus wait; only later advance is frozen.
                    pc_d        = {jump_addr_i[31:1], 1'b0};
                    flush_cnt_d = FLUSH_LAST;
                    jump_taken  = 1'b1;
                    state_d     = stall_o ? HOLD : RUN;
                end else if (stall_o) begin
                    state_d = HOLD;
                end else begin
                    pc_d    = pc_q + 32'd4;
                    state_d = RUN;
                    if (flush_cnt_q != 3'd0) begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end
            end
            default: begin
                flush_o = 1'b1;
            end
        endcase

        // Counters always reload from their own value so a held value persists.
        jump_cnt_d  = jump_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (jump_taken && (jump_cnt_q != 32'hFFFF_FFFF)) begin
            jump_cnt_d = jump_cnt_q + 32'd1;
        end
        if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    assign pc_o        = pc_q;
    assign inst_req_o  = inst_req_q;
    assign halt_o      = halt_q;
    assign jump_cnt_o  = jump_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
